regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the write port of a small 32-bit register bank between two requesters.
//  A Moore FSM grants exclusive ownership and supports multi-cycle write bursts.
//  A hold counter bounds each burst so that a contending requester is never starved.
//  Read access is combinational and independent of arbitration.
//  Sits between two datapath masters (e.g. ALU writeback, load unit) and the bank.
// PARAMETERS
//  DATA_W    32  width of each register / write data
//  ADDR_W    3   address width; bank depth NUM_REGS = 2**ADDR_W
//  MAX_HOLD  4   max consecutive owned cycles while the other side is requesting
// PORTS
//  clk     in   1       rising-edge clock
//  reset   in   1       asynchronous, active-low reset
//  req0    in   1       requester 0 wants/keeps the write port
//  addr0   in   ADDR_W  requester 0 write address
//  wdata0  in   DATA_W  requester 0 write data
//  req1    in   1       requester 1 wants/keeps the write port
//  addr1   in   ADDR_W  requester 1 write address
//  wdata1  in   DATA_W  requester 1 write data
//  gnt0    out  1       requester 0 owns the port (registered)
//  gnt1    out  1       requester 1 owns the port (registered)
//  raddr   in   ADDR_W  read address
//  rdata   out  DATA_W  bank[raddr], combinational, no write bypass
//  busy    out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): all bank registers=0, state=IDLE, gnt0=gnt1=0, busy=0,
//    hold_cnt=0, prio=0 (requester 0 wins the first tie). Reset mid-burst aborts the
//    burst and drops the grant immediately; any write pending at that edge is discarded.
//  - States: IDLE, OWN0, OWN1. gntN=1 iff state==OWNN; busy=(state!=IDLE).
//  - IDLE: req0&req1 -> OWN[prio]; req0 only -> OWN0; req1 only -> OWN1; else stay.
//  - OWNn (other side = m):
//      write: every rising edge with gntn&reqn does bank[addrn]<=wdatan; hold_cnt++.
//      reqn=0 -> OWNm if reqm else IDLE; no write occurs on that edge.
//      reqn=1 & reqm & hold_cnt==MAX_HOLD-1 -> preempt: write this edge, then OWNm.
//      reqn=1 & !reqm -> stay; hold_cnt saturates at MAX_HOLD-1 (unlimited burst).
//  - On every ownership change: hold_cnt<=0 and prio<=other side (round-robin).
//  - Latency: req rising in IDLE at edge k -> gnt high after edge k+1 -> first
//    write at edge k+2. Handover between owners is zero-bubble (one edge).
//  - Only the owner writes, so two masters never write in the same cycle.
//    Non-owner addr/wdata are ignored. Addresses wrap modulo NUM_REGS (no checking).
//  - rdata on the written address shows the old value until the write edge.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10),
//    default widths, MAX_HOLD default.
//  - Sub-module reg_bank_en: NUM_REGS x DATA_W registers with write enable, write
//    address/data, async active-low clear, and a combinational read mux.
//  - Top level: FSM, hold counter, prio flag, and the write mux (owner select).
// TESTING (CLK_PERIOD=20)
//  1 reset=0 -> gnt0=gnt1=0, busy=0, rdata=0 for raddr=0..7; reset=1 -> no change.
//  2 req0=1,addr0=3,wdata0=52 for 1 owned cycle, then req0=0 -> gnt0 seen one edge
//    after req; bank[3]=52; FSM back in IDLE (busy=0).
//  3 req0=req1=1 from IDLE after reset -> gnt0 first. 4 writes addr0=1 (data 10..13),
//    then handover -> gnt1; bank[1]=13; gnt0 and gnt1 never high together.
//  4 req1 alone with req0 low for 10 cycles -> gnt1 holds for all 10 cycles, 10 writes,
//    no preemption.
//  5 mid-burst reset=0 while gnt1=1 -> gnt1=0 and rdata=0 before the next edge;
//    after release, a tie grants requester 0.
//  6 raddr=5 while owner writes 99 to addr 5 -> rdata=old value before the edge,
//    99 after it.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 3;
  localparam int unsigned DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_reg_bank_en.sv
// Register bank with a single enabled write port, async clear and a
// combinational read mux (no write-to-read bypass).
module reg_bank_en
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Storage: clear everything on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-master write arbiter for a small register bank. A Moore FSM grants
// exclusive ownership, a hold counter bounds bursts under contention and a
// round-robin priority flag resolves simultaneous requests from IDLE.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int unsigned       HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              prio_q, prio_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // State, hold counter and priority registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state, burst bound and owner-selected write port.
  // prio always names the side that did not get the most recent grant,
  // so it is updated on entry to an OWN state and left alone on release.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    prio_d  = prio_q;
    we      = 1'b0;
    waddr   = addr0;
    wdata   = wdata0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || !prio_q)) begin
          state_d = ST_OWN0;
          hold_d  = '0;
          prio_d  = 1'b1;
        end else if (req1) begin
          state_d = ST_OWN1;
          hold_d  = '0;
          prio_d  = 1'b0;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          hold_d = '0;
          if (req1) begin
            state_d = ST_OWN1;
            prio_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          we = 1'b1;
          if (req1 && hold_q == HOLD_LAST) begin
            state_d = ST_OWN1;
            hold_d  = '0;
            prio_d  = 1'b0;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_OWN1: begin
        waddr = addr1;
        wdata = wdata1;
        if (!req1) begin
          hold_d = '0;
          if (req0) begin
            state_d = ST_OWN0;
            prio_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          we = 1'b1;
          if (req0 && hold_q == HOLD_LAST) begin
            state_d = ST_OWN0;
            hold_d  = '0;
            prio_d  = 1'b1;
          end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign gnt0 = (state_q == ST_OWN0);
  assign gnt1 = (state_q == ST_OWN1);
  assign busy = (state_q != ST_IDLE);

  reg_bank_en #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  addr0, addr1, raddr;
  logic [31:0] wdata0, wdata1, rdata;
  logic        gnt0, gnt1, busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (3),
    .MAX_HOLD (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .req1   (req1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .raddr  (raddr),
    .rdata  (rdata),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; raddr = '0;

    // 1: reset state
    #2 reset = 1'b0;
    #2;
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_gnt1", {31'd0, gnt1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) read_check("rst_rdata", 3'(i), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rel_gnt0", {31'd0, gnt0}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // 2: single write from requester 0
    req0 = 1'b1; addr0 = 3'd3; wdata0 = 32'd52; raddr = 3'd3;
    #1;
    check("t2_gnt_pre", {31'd0, gnt0}, 32'd0);
    tick();
    check("t2_gnt0", {31'd0, gnt0}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_nowrite", rdata, 32'd0);
    tick();
    check("t2_wr", rdata, 32'd52);
    req0 = 1'b0;
    tick();
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_gnt0_off", {31'd0, gnt0}, 32'd0);
    check("t2_keep", rdata, 32'd52);

    // 3: tie after reset -> requester 0, preempted after 4 writes
    reset = 1'b0;
    #2 reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 3'd1; wdata0 = 32'd10; addr1 = 3'd2; wdata1 = 32'd77;
    tick();
    check("t3_gnt0", {31'd0, gnt0}, 32'd1);
    check("t3_gnt1", {31'd0, gnt1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wdata0 = 32'(10 + i);
      tick();
      check("t3_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      check("t3_g0", {31'd0, gnt0}, (i < 3) ? 32'd1 : 32'd0);
      check("t3_g1", {31'd0, gnt1}, (i < 3) ? 32'd0 : 32'd1);
    end
    read_check("t3_bank1", 3'd1, 32'd13);
    read_check("t3_bank2", 3'd2, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("t3_idle", {31'd0, busy}, 32'd0);
    read_check("t3_nowr", 3'd2, 32'd0);

    // 4: unlimited burst from requester 1, address wraps
    req1 = 1'b1;
    tick();
    check("t4_gnt1", {31'd0, gnt1}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      addr1 = 3'(i); wdata1 = 32'(200 + i);
      tick();
      check("t4_hold", {31'd0, gnt1}, 32'd1);
      read_check("t4_wr", 3'(i), 32'(200 + i));
    end
    read_check("t4_wrap0", 3'd0, 32'd208);
    read_check("t4_wrap1", 3'd1, 32'd209);
    read_check("t4_b2", 3'd2, 32'd202);
    read_check("t4_b7", 3'd7, 32'd207);

    // saturated hold: contender arrives, owner writes once more and hands over
    req0 = 1'b1; addr0 = 3'd4; wdata0 = 32'h44; addr1 = 3'd5; wdata1 = 32'h55;
    tick();
    check("sat_g0", {31'd0, gnt0}, 32'd1);
    check("sat_g1", {31'd0, gnt1}, 32'd0);
    read_check("sat_b5", 3'd5, 32'h55);
    read_check("sat_b4", 3'd4, 32'd204);
    req0 = 1'b0;
    tick();
    check("rel_g1", {31'd0, gnt1}, 32'd1);
    read_check("rel_b4", 3'd4, 32'd204);

    // 5: reset mid-burst
    wdata1 = 32'h56;
    tick();
    read_check("t5_b5", 3'd5, 32'h56);
    #5 reset = 1'b0;
    #1;
    check("t5_gnt1", {31'd0, gnt1}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rdata", rdata, 32'd0);
    req0 = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("t5_tie_g0", {31'd0, gnt0}, 32'd1);
    check("t5_tie_g1", {31'd0, gnt1}, 32'd0);

    // 6: read shows old value until the write edge
    addr0 = 3'd5; wdata0 = 32'd33; raddr = 3'd5;
    tick();
    check("t6_first", rdata, 32'd33);
    wdata0 = 32'd99;
    #1;
    check("t6_old", rdata, 32'd33);
    tick();
    check("t6_new", rdata, 32'd99);
    check("t6_g0", {31'd0, gnt0}, 32'd1);

    req0 = 1'b0; req1 = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
